addsub_serial_ctrl: RTL and testbench



---
 rtl/addsub_serial_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_addsub_serial_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_ctrl.sv
// ---------------------------------------------------------------------------
// addsub_serial_ctrl
//
// Purpose:
//   Sequencer that computes a WIDTH-bit A+B or A-B by driving an external
//   2-bit add/sub slice (adder_sub) one digit per cycle, LSB digit first.
//   The slice sits beside this block and is wired to the slice_* ports. It
//   internally computes slice_a + (slice_b ^ {2{slice_cin}}) + slice_cin.
//   This block pre-conditions slice_b so that the slice effectively computes
//   A_d + (B_d ^ op) + carry on every digit.
//
// Parameters:
//   WIDTH : operand/result width. Must be even and >= 4. N = WIDTH/2 digits.
//
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   start                : request, accepted only when idle
//   op_sub               : 0 = A+B, 1 = A-B (sampled with start)
//   a, b                 : operands (sampled with start)
//   slice_a/b/cin        : digit operands and carry sent to the slice
//   slice_s, slice_cout  : digit sum and carry returned by the slice
//   busy                 : high while digits are being processed
//   done                 : one-cycle pulse, result valid
//   result, cout         : assembled result and final carry (sub: 1 = no borrow)
//   overflow             : two's-complement overflow
//
// Optional feature:
//   ADDSUB_SAT_EN : when defined, an overflowing result is replaced by the
//                   saturated value (0x7F..F for A >= 0, 0x80..0 for A < 0).
// ---------------------------------------------------------------------------
module addsub_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_cin,
    input  logic [1:0]       slice_s,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q;
    logic             op_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;

    // Current digit is brought to bit 0 by a right shift of 2*idx.
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             a_msb, beff_msb, ovf_next;

    assign a_sh = a_q >> {idx_q, 1'b0};
    assign b_sh = b_q >> {idx_q, 1'b0};

    // Sign-based overflow, evaluated while the top digit is on the slice.
    assign a_msb    = a_q[WIDTH-1];
    assign beff_msb = b_q[WIDTH-1] ^ op_q;
    assign ovf_next = (a_msb == beff_msb) && (slice_s[1] != a_msb);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking (<=) assignments so
    // every flop samples values from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM next state and status outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (idx_q == LAST) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slice drive. XORing the carry into slice_b cancels the slice's own
    // B^Cin, leaving A_d + (B_d ^ op) + carry. Outside RUN the slice is
    // held at zero.
    // ------------------------------------------------------------------
    always_comb begin
        slice_a   = 2'b00;
        slice_b   = 2'b00;
        slice_cin = 1'b0;
        if (state == S_RUN) begin
            slice_a   = a_sh[1:0];
            slice_b   = b_sh[1:0] ^ {2{op_q}} ^ {2{carry_q}};
            slice_cin = carry_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, digit sequencing and result assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op_sub;
                        carry_q <= op_sub;  // +1 of the two's-complement negate
                        idx_q   <= '0;
                    end
                end
                S_RUN: begin
                    for (int d = 0; d < N; d++) begin
                        if (idx_q == IDX_W'(d)) result_q[2*d +: 2] <= slice_s;
                    end
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        cout_q <= slice_cout;
                        ovf_q  <= ovf_next;
`ifdef ADDSUB_SAT_EN
                        // Later assignment overrides the top-digit write above.
                        if (ovf_next)
                            result_q <= a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_addsub_serial_ctrl
//
// Directed bench for addsub_serial_ctrl (WIDTH=8) with a behavioural adder_sub
// slice attached. The driver pushes the hand-computed expected response into a
// scoreboard queue; a separate monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_addsub_serial_ctrl;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             op_sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       slice_a, slice_b, slice_s;
    logic             slice_cin, slice_cout;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] result;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             o;
    } exp_t;

    exp_t sb_q[$];

    addsub_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_sub     (op_sub),
        .a          (a),
        .b          (b),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_s    (slice_s),
        .slice_cout (slice_cout),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
        .overflow   (overflow)
    );

    // Behavioural adder_sub slice: a + (b ^ {cin,cin}) + cin.
    logic [2:0] slice_sum;
    assign slice_sum  = {1'b0, slice_a} + {1'b0, slice_b ^ {2{slice_cin}}} + {2'b00, slice_cin};
    assign slice_s    = slice_sum[1:0];
    assign slice_cout = slice_sum[2];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result",   32'(result),   32'(e.r));
                    check("cout",     32'(cout),     32'(e.c));
                    check("overflow", 32'(overflow), 32'(e.o));
                end
            end
        end
    end

    // Issue one operation and supervise its timing. dig enables per-digit
    // slice checks for sub 0x10-0x01; poke pulses start mid-RUN.
    task automatic run_op(input logic op, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] er, input logic ec, input logic eo,
                          input bit dig, input bit poke);
        int  k;
        int  busy_cnt;
        bit  got;
        exp_t e;
        e.r = er; e.c = ec; e.o = eo;
        sb_q.push_back(e);
        @(negedge clk);
        op_sub = op; a = av; b = bv; start = 1'b1;
        @(negedge clk);                       // cycle T+1
        start = 1'b0; a = ~av; b = ~bv; op_sub = ~op;
        k = 1; busy_cnt = 0; got = 0;
        while (!got && k <= 20) begin
            if (busy) busy_cnt++;
            if (dig && k == 1) begin
                check("dig1_cin", 32'(slice_cin), 32'd1);
                check("dig1_b",   32'(slice_b),   32'd1);
            end
            if (dig && k == 2) begin
                check("dig2_cin", 32'(slice_cin), 32'd0);
                check("dig2_b",   32'(slice_b),   32'd3);
            end
            if (poke && k == 2) begin
                start = 1'b1; a = 8'h01; b = 8'h01; op_sub = 1'b1;
            end
            if (poke && k == 3) start = 1'b0;
            if (done) begin
                got = 1;
                check("latency", 32'(k), 32'(N + 1));
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(N));
        @(negedge clk);
        check("done_single", 32'(done),   32'd0);
        check("idle_after",  32'(busy),   32'd0);
        check("result_hold", 32'(result), 32'(er));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_result",   32'(result),    32'd0);
        check("rst_cout",     32'(cout),      32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_slice",    32'({slice_a, slice_b, slice_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Additions
        run_op(1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 0, 0);
`ifdef ADDSUB_SAT_EN
        run_op(1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 0);
        run_op(1'b0, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 0, 0);
`else
        run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0, 0);
        run_op(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0, 0);
`endif
        run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, 0);

        // Subtractions
        run_op(1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1, 0);
        run_op(1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 0, 0);
`ifdef ADDSUB_SAT_EN
        run_op(1'b1, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1, 0, 0);
        run_op(1'b1, 8'h7F, 8'hFF, 8'h7F, 1'b0, 1'b1, 0, 0);
`else
        run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0, 0);
        run_op(1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 0, 0);
`endif

        // start during RUN is ignored
        run_op(1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 0, 1);

        // Reset asserted in the second RUN cycle
        @(negedge clk);
        op_sub = 1'b0; a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_done",     32'(done),     32'd0);
        check("arst_result",   32'(result),   32'd0);
        check("arst_cout",     32'(cout),     32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_slice",    32'({slice_a, slice_b, slice_cin}), 32'd0);
        repeat (3) @(negedge clk);
        check("arst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Recovery after reset
        run_op(1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 0, 0);
        run_op(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
